// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored and both run unsigned.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            dbz_q, dbz_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    acc_hi_q, acc_hi_d;
    logic [W-1:0]    acc_lo_q, acc_lo_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [W-1:0]    step_hi, step_lo, res_hi, res_lo;
    logic            last_step;

    assign last_step = (cnt_q == CW'(W - 1));

`ifdef MDU_SIGNED_EN
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;
    logic signed_op;
    logic [2*W-1:0] prod_fix;

    assign signed_op = op[0];
    assign a_mag = (signed_op && a[W-1]) ? -a : a;
    assign b_mag = (signed_op && b[W-1]) ? -b : b;

    always_comb begin
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (state_q == IDLE && start) begin
            neg_res_d = signed_op & (a[W-1] ^ b[W-1]);
            neg_rem_d = signed_op & a[W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Product negates as one 2W-bit value; quotient and remainder negate independently.
    always_comb begin
        prod_fix = neg_res_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        if (is_div_q) begin
            res_lo = neg_res_q ? -step_lo : step_lo;
            res_hi = neg_rem_q ? -step_hi : step_hi;
        end else begin
            res_lo = prod_fix[W-1:0];
            res_hi = prod_fix[2*W-1:W];
        end
    end
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign a_mag  = a;
    assign b_mag  = b;
    assign res_hi = step_hi;
    assign res_lo = step_lo;
`endif

    // One radix-2 step; acc_hi is the partial product / remainder, acc_lo the multiplier / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
        div_shift = {acc_hi_q, acc_lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            step_lo = {acc_lo_q[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo_q[W-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == IDLE) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
                cnt_d    = '0;
                is_div_d = op[1];
                dbz_d    = op[1] && (b == '0);
                acc_hi_d = '0;
                acc_lo_d = op[1] ? a_mag : b_mag;
                opnd_d   = op[1] ? b_mag : a_mag;
            end
        end else if (state_q == CALC) begin
            cnt_d    = cnt_q + CW'(1);
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            if (last_step) begin
                hi_d = res_hi;
                lo_d = dbz_q ? '1 : res_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == FIN);
        div_by_zero = (state_q == FIN) && dbz_q;
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO/flag values come from a 64-bit arithmetic model
// pushed to a scoreboard queue at issue and popped when done pulses.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        logic   sgn;
        longint sx, sy, p, q, r;
`ifdef MDU_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        e.dbz = 1'b0;
        if (!o[1]) begin
            p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
        int   n;
        int   busy_bad;
        bit   got;
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy_rise"}, busy, 1);
        n = 0; got = 1'b0; busy_bad = 0;
        while (!got && n < 40) begin
            if (inject) begin
                case (n)
                    10: begin start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; end
                    11: start = 1'b0;
                    12: begin lo_we = 1'b1; wdata = 32'h0000_AAAA; end
                    13: lo_we = 1'b0;
                    default: ;
                endcase
            end
            @(negedge clk);
            n++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) got = 1'b1;
        end
        check({name, ".latency"}, n, 32);
        check({name, ".busy_hold"}, busy_bad, 0);
        e = sb_q.pop_front();
        check({name, ".hi"}, hi, e.hi);
        check({name, ".lo"}, lo, e.lo);
        check({name, ".dbz"}, div_by_zero, e.dbz);
        @(negedge clk);
        check({name, ".after_done_busy_dbz"}, {done, busy, div_by_zero}, 3'b000);
        check({name, ".hold_lo"}, lo, e.lo);
        $display("op %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b", name, x, y, e.hi, e.lo, e.dbz);
    endtask

    initial begin
        exp_t unused_e;
        repeat (2) @(negedge clk);
        check("reset.flags", {busy, done, div_by_zero}, 3'b000);
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        rst_n = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max.const_hi", hi, 32'hFFFF_FFFE);
        run_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        check("divu_100_7.const_lo", lo, 32'd14);
        run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_minint_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_minint_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_neg_by_zero", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("divu_by_zero", 2'b10, 32'h0000_1234, 32'd0, 1'b0);

        run_op("multu_6x7_inject", 2'b00, 32'd6, 32'd7, 1'b1);
        check("inject.const_lo", lo, 32'd42);

        @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo_idle.lo", lo, 32'h0000_AAAA);
        check("mtlo_idle.hi_kept", hi, 32'd0);
        @(negedge clk); hi_we = 1'b1; wdata = 32'h5555_0001;
        @(negedge clk); hi_we = 1'b0;
        check("mthi_idle.hi", hi, 32'h5555_0001);
        check("mthi_idle.lo_kept", lo, 32'h0000_AAAA);
        $display("mtlo/mthi in idle -> hi=0x%08h lo=0x%08h", hi, lo);

        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        sb_q.push_back(model(2'b10, 32'd1000, 32'd3));
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        unused_e = sb_q.pop_back();
        #1;
        check("midreset.flags", {busy, done, div_by_zero}, 3'b000);
        check("midreset.hi", hi, 0);
        check("midreset.lo", lo, 0);
        $display("async reset mid-divide -> busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midreset.queue_empty", sb_q.size(), 0);
        run_op("divu_after_reset", 2'b10, 32'd100, 32'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
